// File: rtl/romulator_load_ctrl.sv
// romulator_load_ctrl
// Boot/reload sequencer for the ROMulator. It holds the target CPU in reset,
// latches the flash image index and runs the SPI flash loader, with a timeout
// on the load. It then hands the shared 64K RAM port to the CPU. A reload
// request reclaims the port and repeats the whole sequence.
//
// Handshake/ownership contract: the RAM port has exactly one owner at a time,
// selected by the registered bus_owner (0 none, 1 loader, 2 CPU). Only the
// owner's strobes and address/data reach the ram_* outputs. With no owner,
// every ram_* output is driven to zero.

module romulator_load_ctrl #(
    parameter int          RESET_HOLD     = 16,
    parameter int          SETTLE_CYCLES  = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  cfg_sel,
    input  logic        reload_req,
    output logic        loader_en,
    output logic [3:0]  loader_cfg,
    input  logic        loader_done,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_din,
    input  logic        ld_cs,
    input  logic        ld_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_datain,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        cpu_reset_n,
    output logic [1:0]  bus_owner,
    output logic        load_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RUN    = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [1:0]  OWNER_NONE   = 2'd0;
    localparam logic [1:0]  OWNER_LOADER = 2'd1;
    localparam logic [1:0]  OWNER_CPU    = 2'd2;

    localparam logic [15:0] HOLD_LAST    = 16'(RESET_HOLD - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;
    localparam logic [23:0] TCNT_MAX     = 24'hFF_FFFF;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] phase_cnt;     // hold/settle duration, cleared on each state entry
    logic [23:0] timeout_cnt;   // LOAD cycles elapsed, saturating
    logic [3:0]  cfg_s1;
    logic [3:0]  cfg_s2;
    logic        reload_prev;
    logic        reload_rise;

    // A reload is one rising edge of the raw request against its registered copy.
    assign reload_rise = reload_req & ~reload_prev;

    // Next-state selection; reload edges only matter in RUN and FAULT, so edges
    // seen in any other state are simply dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HOLD:   if (phase_cnt == HOLD_LAST) state_nxt = ST_LATCH;
            ST_LATCH:  state_nxt = ST_LOAD;
            ST_LOAD: begin
                // completion takes priority over a timeout in the same cycle
                if (loader_done)                       state_nxt = ST_SETTLE;
                else if (timeout_cnt == TIMEOUT_LAST)  state_nxt = ST_FAULT;
            end
            ST_SETTLE: if (phase_cnt == SETTLE_LAST) state_nxt = ST_RUN;
            ST_RUN:    if (reload_rise) state_nxt = ST_HOLD;
            ST_FAULT:  if (reload_rise) state_nxt = ST_HOLD;
            default:   state_nxt = ST_HOLD;
        endcase
    end

    // Sequencer state, counters, synchronizers and Moore outputs decoded from
    // the state being entered, so outputs change on the entering edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HOLD;
            phase_cnt   <= 16'd0;
            timeout_cnt <= 24'd0;
            cfg_s1      <= 4'd0;
            cfg_s2      <= 4'd0;
            reload_prev <= 1'b0;
            loader_cfg  <= 4'd0;
            loader_en   <= 1'b0;
            cpu_reset_n <= 1'b0;
            bus_owner   <= OWNER_NONE;
            load_error  <= 1'b0;
            busy        <= 1'b1;
        end else begin
            cfg_s1      <= cfg_sel;
            cfg_s2      <= cfg_s1;
            reload_prev <= reload_req;
            state       <= state_nxt;

            if (state_nxt != state) phase_cnt <= 16'd0;
            else                    phase_cnt <= phase_cnt + 16'd1;

            if (state_nxt == ST_LOAD && state != ST_LOAD)
                timeout_cnt <= 24'd0;
            else if (state == ST_LOAD && timeout_cnt != TCNT_MAX)
                timeout_cnt <= timeout_cnt + 24'd1;

            if (state == ST_LATCH) loader_cfg <= cfg_s2;

            loader_en   <= (state_nxt == ST_LOAD);
            cpu_reset_n <= (state_nxt == ST_RUN);
            load_error  <= (state_nxt == ST_FAULT);
            busy        <= (state_nxt != ST_RUN);
            case (state_nxt)
                ST_LOAD: bus_owner <= OWNER_LOADER;
                ST_RUN:  bus_owner <= OWNER_CPU;
                default: bus_owner <= OWNER_NONE;
            endcase
        end
    end

    // RAM port mux driven purely by the registered owner.
    always_comb begin
        ram_address = 16'd0;
        ram_datain  = 8'd0;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        case (bus_owner)
            OWNER_LOADER: begin
                ram_address = ld_addr;
                ram_datain  = ld_din;
                ram_cs      = ld_cs;
                ram_we      = ld_we;
            end
            OWNER_CPU: begin
                ram_address = cpu_addr;
                ram_datain  = cpu_din;
                ram_cs      = cpu_cs;
                ram_we      = cpu_we;
            end
            default: begin
                ram_address = 16'd0;
                ram_datain  = 8'd0;
                ram_cs      = 1'b0;
                ram_we      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_romulator_load_ctrl.sv
// Directed bench for romulator_load_ctrl: boot, mux isolation, reload, reset
// mid-load, timeout and the done-versus-timeout tie.

module tb_romulator_load_ctrl;

    localparam logic [23:0] TO = 24'd50;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cfg_sel;
    logic        reload_req;
    logic        loader_en;
    logic [3:0]  loader_cfg;
    logic        loader_done;
    logic [15:0] ld_addr;
    logic [7:0]  ld_din;
    logic        ld_cs;
    logic        ld_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_cs;
    logic        cpu_we;
    logic [15:0] ram_address;
    logic [7:0]  ram_datain;
    logic        ram_cs;
    logic        ram_we;
    logic        cpu_reset_n;
    logic [1:0]  bus_owner;
    logic        load_error;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    romulator_load_ctrl #(
        .RESET_HOLD    (16),
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_sel     (cfg_sel),
        .reload_req  (reload_req),
        .loader_en   (loader_en),
        .loader_cfg  (loader_cfg),
        .loader_done (loader_done),
        .ld_addr     (ld_addr),
        .ld_din      (ld_din),
        .ld_cs       (ld_cs),
        .ld_we       (ld_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_cs      (cpu_cs),
        .cpu_we      (cpu_we),
        .ram_address (ram_address),
        .ram_datain  (ram_datain),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .cpu_reset_n (cpu_reset_n),
        .bus_owner   (bus_owner),
        .load_error  (load_error),
        .busy        (busy)
    );

    // clock
    always #5 clk = ~clk;

    // one active edge, then settle 1 time unit before driving or sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cfg_sel     = 4'h3;
        reload_req  = 1'b0;
        loader_done = 1'b0;
        ld_addr     = 16'h0040;
        ld_din      = 8'h11;
        ld_cs       = 1'b1;
        ld_we       = 1'b1;
        cpu_addr    = 16'h0080;
        cpu_din     = 8'h22;
        cpu_cs      = 1'b1;
        cpu_we      = 1'b1;
        repeat (3) tick();

        // reset values, with both requesters strobing
        check("rst_cpu_reset_n", cpu_reset_n, 0);
        check("rst_loader_en",   loader_en,   0);
        check("rst_loader_cfg",  loader_cfg,  0);
        check("rst_owner",       bus_owner,   0);
        check("rst_ram_cs",      ram_cs,      0);
        check("rst_ram_we",      ram_we,      0);
        check("rst_ram_addr",    ram_address, 0);
        check("rst_load_error",  load_error,  0);
        check("rst_busy",        busy,        1);

        // normal boot: 16 HOLD + 1 LATCH, LOAD entered on edge 17
        rst = 1'b0;
        repeat (16) tick();
        check("boot_e16_owner",  bus_owner,   0);
        check("boot_e16_rstn",   cpu_reset_n, 0);
        check("boot_e16_ld_en",  loader_en,   0);
        tick();
        check("boot_load_owner", bus_owner,   1);
        check("boot_load_en",    loader_en,   1);
        check("boot_load_cfg",   loader_cfg,  3);
        check("boot_load_busy",  busy,        1);

        // mux isolation in LOAD
        ld_addr = 16'h1234; ld_din = 8'hAB; ld_cs = 1'b1; ld_we = 1'b0;
        cpu_addr = 16'hFFFC; cpu_din = 8'h5A; cpu_cs = 1'b1; cpu_we = 1'b1;
        #1;
        check("load_mux_addr", ram_address, 16'h1234);
        check("load_mux_data", ram_datain,  8'hAB);
        check("load_mux_cs",   ram_cs,      1);
        check("load_mux_we",   ram_we,      0);
        ld_cs = 1'b0; cpu_cs = 1'b1; cpu_we = 1'b0;
        #1;
        check("load_mux_cs_off", ram_cs, 0);
        ld_we = 1'b1; cpu_we = 1'b1;
        #1;
        check("load_mux_we_on",  ram_we, 1);

        // done after 30 LOAD cycles
        repeat (29) tick();
        check("load_still", bus_owner, 1);
        loader_done = 1'b1;
        tick();
        loader_done = 1'b0;
        check("settle_owner", bus_owner,   0);
        check("settle_ld_en", loader_en,   0);
        check("settle_rstn",  cpu_reset_n, 0);
        repeat (3) tick();
        check("settle_e4_owner", bus_owner, 0);
        tick();
        check("run_rstn",  cpu_reset_n, 1);
        check("run_owner", bus_owner,   2);
        check("run_busy",  busy,        0);

        // mux isolation in RUN
        ld_addr = 16'h1111; ld_din = 8'h99; ld_cs = 1'b1; ld_we = 1'b1;
        cpu_addr = 16'hFFFC; cpu_din = 8'h5A; cpu_cs = 1'b1; cpu_we = 1'b1;
        #1;
        check("run_mux_addr", ram_address, 16'hFFFC);
        check("run_mux_data", ram_datain,  8'h5A);
        check("run_mux_we",   ram_we,      1);
        cpu_cs = 1'b0; cpu_we = 1'b0;
        #1;
        check("run_mux_cs_off", ram_cs, 0);
        check("run_mux_we_off", ram_we, 0);

        // reload from RUN, request held high 30 cycles
        cfg_sel = 4'h7;
        repeat (3) tick();
        check("run_stays", bus_owner, 2);
        reload_req = 1'b1;
        tick();
        check("reload_rstn",  cpu_reset_n, 0);
        check("reload_owner", bus_owner,   0);
        check("reload_busy",  busy,        1);
        repeat (17) tick();
        check("reload_load_owner", bus_owner,  1);
        check("reload_load_cfg",   loader_cfg, 7);
        repeat (12) tick();
        reload_req = 1'b0;
        tick();
        check("held_req_one_reload", bus_owner, 1);
        // a fresh pulse during LOAD is discarded
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
        tick();
        check("load_ignores_reload", bus_owner, 1);
        check("load_ignores_en",     loader_en, 1);

        // reset mid-LOAD aborts the load on the same edge
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ld_en", loader_en,   0);
        check("midrst_owner", bus_owner,   0);
        check("midrst_cfg",   loader_cfg,  0);
        check("midrst_busy",  busy,        1);
        repeat (16) tick();
        check("restart_e16_owner", bus_owner, 0);
        tick();
        check("restart_load_owner", bus_owner,  1);
        check("restart_load_cfg",   loader_cfg, 7);

        // timeout: FAULT entered after exactly 50 LOAD cycles
        repeat (49) tick();
        check("to_e49_owner", bus_owner,  1);
        check("to_e49_err",   load_error, 0);
        tick();
        check("fault_err",   load_error,  1);
        check("fault_ld_en", loader_en,   0);
        check("fault_rstn",  cpu_reset_n, 0);
        check("fault_owner", bus_owner,   0);
        repeat (3) tick();
        check("fault_sticky", load_error, 1);
        reload_req = 1'b1;
        tick();
        reload_req = 1'b0;
        check("fault_clear_err",   load_error, 0);
        check("fault_clear_owner", bus_owner,  0);

        // done on the final timeout cycle wins
        repeat (17) tick();
        check("tie_load_owner", bus_owner, 1);
        repeat (49) tick();
        check("tie_e49_owner", bus_owner, 1);
        loader_done = 1'b1;
        tick();
        loader_done = 1'b0;
        check("tie_settle_owner", bus_owner,  0);
        check("tie_settle_err",   load_error, 0);
        repeat (4) tick();
        check("tie_run_owner", bus_owner,   2);
        check("tie_run_rstn",  cpu_reset_n, 1);
        check("tie_run_err",   load_error,  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
